// File: rtl/player_ctrl.sv
// Player controller: per-frame movement with arena/pillar collision, blast damage with
// invulnerability window, and edge-triggered tile-snapped bomb drops with cooldown.
module player_ctrl #(
  parameter logic [7:0]  KEY_UP        = 8'h52,
  parameter logic [7:0]  KEY_DOWN      = 8'h51,
  parameter logic [7:0]  KEY_LEFT      = 8'h50,
  parameter logic [7:0]  KEY_RIGHT     = 8'h4F,
  parameter logic [7:0]  KEY_BOMB      = 8'h13,
  parameter int unsigned STEP          = 1,
  parameter int unsigned W             = 19,
  parameter int unsigned H             = 26,
  parameter int unsigned X_MIN         = 32,
  parameter int unsigned X_MAX         = 575,
  parameter int unsigned Y_MIN         = 32,
  parameter int unsigned Y_MAX         = 447,
  parameter int unsigned TILE          = 64,
  parameter int unsigned ORIGIN        = 32,
  parameter int unsigned SPAWN_X       = 544,
  parameter int unsigned SPAWN_Y       = 416,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned INVULN_FRAMES = 120,
  parameter int unsigned BOMB_COOLDOWN = 60
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       blast_valid,
  input  logic [9:0] blast_x,
  input  logic [9:0] blast_y,
  input  logic [9:0] blast_w,
  input  logic [9:0] blast_h,
  output logic [9:0] userX,
  output logic [9:0] userY,
  output logic [2:0] heart,
  output logic       bomb_drop,
  output logic [9:0] drop_x,
  output logic [9:0] drop_y,
  output logic       damage,
  output logic       collide,
  output logic       dead
);

  localparam int unsigned AW   = 12;
  localparam int unsigned TBIT = $clog2(TILE);
  localparam int unsigned IW   = $clog2(INVULN_FRAMES + 2);
  localparam int unsigned CW   = $clog2(BOMB_COOLDOWN + 2);

  localparam logic [AW-1:0] STEP_A  = AW'(STEP);
  localparam logic [AW-1:0] W_A     = AW'(W);
  localparam logic [AW-1:0] H_A     = AW'(H);
  localparam logic [AW-1:0] WM1_A   = AW'(W - 1);
  localparam logic [AW-1:0] HM1_A   = AW'(H - 1);
  localparam logic [AW-1:0] WH_A    = AW'(W / 2);
  localparam logic [AW-1:0] HH_A    = AW'(H / 2);
  localparam logic [AW-1:0] XMIN_A  = AW'(X_MIN);
  localparam logic [AW-1:0] XMAX_A  = AW'(X_MAX);
  localparam logic [AW-1:0] YMIN_A  = AW'(Y_MIN);
  localparam logic [AW-1:0] YMAX_A  = AW'(Y_MAX);
  localparam logic [AW-1:0] ORG_A   = AW'(ORIGIN);
  localparam logic [AW-1:0] TMASK_A = ~(AW'(TILE - 1));
  localparam logic [10:0]   W11     = 11'(W);
  localparam logic [10:0]   H11     = 11'(H);
  localparam logic [IW-1:0] INV_LD  = IW'(INVULN_FRAMES);
  localparam logic [CW-1:0] COOL_LD = CW'(BOMB_COOLDOWN);

  if (W >= TILE / 2 || H >= TILE / 2) begin : g_bad_hitbox
    $error("player_ctrl: hitbox must be narrower than half a tile");
  end
  if (LIVES < 1 || LIVES > 7) begin : g_bad_lives
    $error("player_ctrl: LIVES must be 1..7");
  end

  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

  state_t        state_q, state_d;
  logic [9:0]    ux_q, ux_d, uy_q, uy_d, dx_q, dx_d, dy_q, dy_d;
  logic [2:0]    heart_q, heart_d;
  logic [IW-1:0] inv_q, inv_d;
  logic [CW-1:0] cool_q, cool_d;
  logic          bombk_q, bombk_d, drop_q, drop_d, dmg_q, dmg_d;
  logic          col_q, col_d, dead_q, dead_d;

  function automatic logic in_band(input logic [AW-1:0] c);
    return 1'((c - ORG_A) >> (TBIT - 1));
  endfunction

  logic [10:0] ux11, uy11, bx11, by11, bxe, bye, uxe, uye;
  logic        overlap, bomb_edge, cand_ok;
  logic [AW-1:0] cx, cy;

  assign ux11 = {1'b0, ux_q};
  assign uy11 = {1'b0, uy_q};
  assign bx11 = {1'b0, blast_x};
  assign by11 = {1'b0, blast_y};
  assign bxe  = bx11 + {1'b0, blast_w};
  assign bye  = by11 + {1'b0, blast_h};
  assign uxe  = ux11 + W11;
  assign uye  = uy11 + H11;
  assign overlap = blast_valid && (ux11 < bxe) && (bx11 < uxe) && (uy11 < bye) && (by11 < uye);
  assign bomb_edge = (keycode == KEY_BOMB) && !bombk_q;

  always_comb begin
    cx = {2'b00, ux_q};
    cy = {2'b00, uy_q};
    case (keycode)
      KEY_UP:    cy = cy - STEP_A;
      KEY_DOWN:  cy = cy + STEP_A;
      KEY_LEFT:  cx = cx - STEP_A;
      KEY_RIGHT: cx = cx + STEP_A;
      default:   ;
    endcase
  end

  // Upper-bit test rejects candidates that wrapped below zero before the sums are trusted.
  assign cand_ok = (cx[AW-1:10] == '0) && (cy[AW-1:10] == '0) &&
                   (cx >= XMIN_A) && (cx + W_A <= XMAX_A) &&
                   (cy >= YMIN_A) && (cy + H_A <= YMAX_A) &&
                   !((in_band(cx) || in_band(cx + WM1_A)) && (in_band(cy) || in_band(cy + HM1_A)));

  always_comb begin
    state_d = state_q;
    ux_d    = ux_q;
    uy_d    = uy_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    heart_d = heart_q;
    inv_d   = inv_q;
    cool_d  = (cool_q != '0) ? cool_q - CW'(1) : '0;
    bombk_d = (keycode == KEY_BOMB);
    drop_d  = 1'b0;
    dmg_d   = 1'b0;
    if (state_q == ALIVE && overlap) begin
      heart_d = heart_q - 3'd1;
      dmg_d   = 1'b1;
      ux_d    = 10'(SPAWN_X);
      uy_d    = 10'(SPAWN_Y);
      cool_d  = cool_q;
      if (heart_q == 3'd1) begin
        state_d = DEAD;
      end else begin
        state_d = INVULN;
        inv_d   = INV_LD;
      end
    end else if (state_q != DEAD) begin
      if (state_q == INVULN) begin
        inv_d = inv_q - IW'(1);
        if (inv_q == IW'(1)) state_d = ALIVE;
      end
      if (cand_ok) begin
        ux_d = cx[9:0];
        uy_d = cy[9:0];
      end
      if (bomb_edge && cool_q == '0) begin
        drop_d = 1'b1;
        cool_d = COOL_LD;
        dx_d   = 10'((({2'b00, ux_q} + WH_A - ORG_A) & TMASK_A) + ORG_A);
        dy_d   = 10'((({2'b00, uy_q} + HH_A - ORG_A) & TMASK_A) + ORG_A);
      end
    end
    col_d  = (state_d == INVULN);
    dead_d = (state_d == DEAD);
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ALIVE;
      ux_q    <= 10'(SPAWN_X);
      uy_q    <= 10'(SPAWN_Y);
      dx_q    <= '0;
      dy_q    <= '0;
      heart_q <= 3'(LIVES);
      inv_q   <= '0;
      cool_q  <= '0;
      bombk_q <= 1'b0;
      drop_q  <= 1'b0;
      dmg_q   <= 1'b0;
      col_q   <= 1'b0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ux_q    <= ux_d;
      uy_q    <= uy_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      heart_q <= heart_d;
      inv_q   <= inv_d;
      cool_q  <= cool_d;
      bombk_q <= bombk_d;
      drop_q  <= drop_d;
      dmg_q   <= dmg_d;
      col_q   <= col_d;
      dead_q  <= dead_d;
    end
  end

  assign userX     = ux_q;
  assign userY     = uy_q;
  assign heart     = heart_q;
  assign bomb_drop = drop_q;
  assign drop_x    = dx_q;
  assign drop_y    = dy_q;
  assign damage    = dmg_q;
  assign collide   = col_q;
  assign dead      = dead_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: directed scenarios plus long random runs, every frame checked
// against a frame-level behavioural model of the player.
module tb_player_ctrl;

  localparam logic [7:0] K_UP = 8'h52, K_DN = 8'h51, K_LT = 8'h50, K_RT = 8'h4F, K_BM = 8'h13;
  localparam int PW = 19, PH = 26, XMN = 32, XMX = 575, YMN = 32, YMX = 447;
  localparam int TL = 64, OG = 32, SX = 544, SY = 416, NL = 3, INV = 120, CD = 60, STP = 1;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] keycode = '0;
  logic       blast_valid = 1'b0;
  logic [9:0] blast_x = '0, blast_y = '0, blast_w = '0, blast_h = '0;
  logic [9:0] userX, userY, drop_x, drop_y;
  logic [2:0] heart;
  logic       bomb_drop, damage, collide, dead;

  player_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .blast_valid(blast_valid),
    .blast_x(blast_x), .blast_y(blast_y), .blast_w(blast_w), .blast_h(blast_h),
    .userX(userX), .userY(userY), .heart(heart), .bomb_drop(bomb_drop),
    .drop_x(drop_x), .drop_y(drop_y), .damage(damage), .collide(collide), .dead(dead)
  );

  always #5 frame_clk = ~frame_clk;

  int n_cmp = 0, n_bad = 0;
  int m_x, m_y, m_lives, m_inv, m_cool, m_dx, m_dy;
  bit m_dead, m_prev, e_drop, e_dmg;
  int n_drop, n_col, n_dmg;

  function automatic bit band(input int c);
    return (((c - OG) % TL + TL) % TL) >= TL / 2;
  endfunction

  function automatic bit box_free(input int x, input int y);
    int xs[2], ys[2];
    if (x < XMN || x + PW > XMX || y < YMN || y + PH > YMX) return 1'b0;
    xs = '{x, x + PW - 1};
    ys = '{y, y + PH - 1};
    foreach (xs[i]) foreach (ys[j]) if (band(xs[i]) && band(ys[j])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("userX", int'(userX), m_x);
    check("userY", int'(userY), m_y);
    check("heart", int'(heart), m_lives);
    check("bomb_drop", int'(bomb_drop), int'(e_drop));
    check("drop_x", int'(drop_x), m_dx);
    check("drop_y", int'(drop_y), m_dy);
    check("damage", int'(damage), int'(e_dmg));
    check("collide", int'(collide), int'(!m_dead && m_inv > 0));
    check("dead", int'(dead), int'(m_dead));
  endtask

  task automatic do_reset();
    @(negedge frame_clk);
    #2 Reset = 1'b0;
    #1;
    m_x = SX; m_y = SY; m_lives = NL; m_inv = 0; m_cool = 0; m_dx = 0; m_dy = 0;
    m_dead = 0; m_prev = 0; e_drop = 0; e_dmg = 0;
    check_all();
    @(negedge frame_clk);
    keycode = '0; blast_valid = 1'b0; Reset = 1'b1;
  endtask

  task automatic frame(input logic [7:0] k, input bit bv, input int bx, input int by,
                       input int bw, input int bh);
    bit hit, bomb_edge;
    int nx, ny;
    @(negedge frame_clk);
    keycode = k; blast_valid = bv;
    blast_x = 10'(bx); blast_y = 10'(by); blast_w = 10'(bw); blast_h = 10'(bh);
    @(posedge frame_clk);
    hit = !m_dead && m_inv == 0 && bv && m_x < bx + bw && bx < m_x + PW &&
          m_y < by + bh && by < m_y + PH;
    bomb_edge = (k == K_BM) && !m_prev;
    e_dmg = 0; e_drop = 0;
    if (m_dead) begin
      if (m_cool > 0) m_cool--;
    end else if (hit) begin
      m_lives--; e_dmg = 1; m_x = SX; m_y = SY;
      if (m_lives == 0) m_dead = 1; else m_inv = INV;
    end else begin
      if (m_inv > 0) m_inv--;
      if (bomb_edge && m_cool == 0) begin
        e_drop = 1; m_cool = CD;
        m_dx = ((m_x + PW / 2 - OG) / TL) * TL + OG;
        m_dy = ((m_y + PH / 2 - OG) / TL) * TL + OG;
      end else if (m_cool > 0) m_cool--;
      nx = m_x; ny = m_y;
      if (k == K_UP) ny -= STP;
      else if (k == K_DN) ny += STP;
      else if (k == K_LT) nx -= STP;
      else if (k == K_RT) nx += STP;
      if (box_free(nx, ny)) begin m_x = nx; m_y = ny; end
    end
    m_prev = (k == K_BM);
    #1;
    check_all();
    n_drop += int'(bomb_drop);
    n_col  += int'(collide);
    n_dmg  += int'(damage);
  endtask

  initial begin
    logic [7:0] k;
    int run, bx, by;
    do_reset();

    // Right wall
    repeat (20) frame(K_RT, 0, 0, 0, 0, 0);
    check("right_bound_x", int'(userX), 556);
    check("right_bound_y", int'(userY), 416);

    // Pillar corner blocks upward motion
    do_reset();
    repeat (8) frame(K_LT, 0, 0, 0, 0, 0);
    check("left8_x", int'(userX), 536);
    repeat (5) frame(K_UP, 0, 0, 0, 0, 0);
    check("pillar_y", int'(userY), 416);

    // Damage, invulnerability window, death
    do_reset();
    n_col = 0; n_dmg = 0;
    for (int f = 0; f <= 130; f++) begin
      frame(8'h00, (f == 0 || f == 50), 512, 416, 64, 32);
      if (f == 0) begin
        check("first_damage", int'(damage), 1);
        check("first_heart", int'(heart), 2);
      end
    end
    check("collide_frames", n_col, INV);
    check("damage_pulses", n_dmg, 1);
    frame(8'h00, 1, 512, 416, 64, 32);
    check("second_heart", int'(heart), 1);
    repeat (125) frame(8'h00, 0, 0, 0, 0, 0);
    frame(8'h00, 1, 512, 416, 64, 32);
    check("final_heart", int'(heart), 0);
    check("final_dead", int'(dead), 1);
    for (int f = 0; f < 6; f++) frame((f % 2) ? K_BM : K_LT, 1, 512, 416, 64, 32);
    check("dead_frozen_x", int'(userX), SX);
    check("dead_no_drop", int'(bomb_drop), 0);

    // Bomb edge detection and cooldown
    do_reset();
    n_drop = 0;
    for (int f = 0; f <= 60; f++) frame((f < 10 || f == 30) ? K_BM : 8'h00, 0, 0, 0, 0, 0);
    check("one_drop", n_drop, 1);
    check("drop_x_snap", int'(drop_x), 544);
    check("drop_y_snap", int'(drop_y), 416);
    frame(K_BM, 0, 0, 0, 0, 0);
    check("cooldown_expired_drop", int'(bomb_drop), 1);

    // Damage beats bomb; reset aborts invulnerability and cooldown
    do_reset();
    frame(K_BM, 1, 512, 416, 64, 32);
    check("tie_damage", int'(damage), 1);
    check("tie_no_drop", int'(bomb_drop), 0);
    frame(8'h00, 0, 0, 0, 0, 0);
    frame(K_BM, 0, 0, 0, 0, 0);
    repeat (10) frame(K_LT, 0, 0, 0, 0, 0);
    check("mid_invuln_collide", int'(collide), 1);
    do_reset();
    check("reset_heart", int'(heart), 3);
    check("reset_collide", int'(collide), 0);
    frame(K_BM, 0, 0, 0, 0, 0);
    check("post_reset_drop", int'(bomb_drop), 1);

    // Random runs of held keys with sporadic blasts and resets
    run = 0;
    for (int r = 0; r < 500; r++) begin
      case ($urandom_range(0, 9))
        0, 1:    k = K_UP;
        2, 3:    k = K_DN;
        4, 5:    k = K_LT;
        6, 7:    k = K_RT;
        8:       k = K_BM;
        default: k = 8'($urandom);
      endcase
      for (int s = 0; s < int'($urandom_range(1, 14)); s++) begin
        bx = m_x + int'($urandom_range(0, 160)) - 80;
        by = m_y + int'($urandom_range(0, 160)) - 80;
        if (bx < 0) bx = 0;
        if (by < 0) by = 0;
        frame((k == K_BM && s % 3 == 2) ? 8'h00 : k, ($urandom_range(0, 24) == 0), bx, by,
              int'($urandom_range(1, 64)), int'($urandom_range(1, 64)));
        run++;
        if (run % 400 == 0) do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/player_ctrl.md
PLAYER_CTRL -- requirements
Module: player_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- KEY_UP 8'h52: up keycode
- KEY_DOWN 8'h51: down keycode
- KEY_LEFT 8'h50: left keycode
- KEY_RIGHT 8'h4F: right keycode
- KEY_BOMB 8'h13: bomb keycode
- STEP 1: pixels moved per frame
- W 19, H 26: hitbox width and height
- X_MIN 32, X_MAX 575, Y_MIN 32, Y_MAX 447: arena bounds
- TILE 64, ORIGIN 32: pillar grid pitch (power of two) and offset
- SPAWN_X 544, SPAWN_Y 416: spawn position
- LIVES 3: initial hearts, 1..7
- INVULN_FRAMES 120: invulnerability length
- BOMB_COOLDOWN 60: frames between drops
REQ-002 Ports (name, direction, width, meaning):
- frame_clk in 1: the only clock
- Reset in 1: asynchronous, active-low reset
- keycode in 8: current key
- blast_valid in 1: blast box active
- blast_x, blast_y, blast_w, blast_h in 10 each: blast box
- userX, userY out 10 each: hitbox top-left
- heart out 3: remaining hearts
- bomb_drop out 1: one-frame pulse
- drop_x, drop_y out 10 each: tile-snapped bomb position
- damage out 1: one-frame pulse
- collide out 1: high while INVULN
- dead out 1: high in DEAD
REQ-003 All outputs SHALL be registered on frame_clk.

Function
REQ-004 FSM states SHALL be ALIVE, INVULN and DEAD.
REQ-005 Coordinate c SHALL be in a pillar band when ((c-ORIGIN) mod TILE) >= TILE/2.
REQ-006 A box SHALL be blocked when any of its four corners (x,y), (x+W-1,y), (x,y+H-1), (x+W-1,y+H-1) has both coordinates in a band.
REQ-007 W and H SHALL be less than TILE/2 (elaborate-time check).
REQ-008 Each edge in ALIVE or INVULN, a direction key SHALL form a candidate position = position ± STEP on that axis.
REQ-009 The candidate SHALL be accepted only if x>=X_MIN, x+W<=X_MAX, y>=Y_MIN, y+H<=Y_MAX and the box is not blocked; otherwise position holds. No bounce, no rollback.
REQ-010 No direction key SHALL mean no motion; motion is never latched.
REQ-011 Blast overlap SHALL be: blast_valid && userX<blast_x+blast_w && blast_x<userX+W && userY<blast_y+blast_h && blast_y<userY+H, evaluated with 11-bit sums.
REQ-012 On overlap in ALIVE, in one edge: heart <= heart-1; damage <= 1; position <= spawn; state <= DEAD if heart was 1, else INVULN with counter loaded to INVULN_FRAMES.
REQ-013 INVULN SHALL ignore blasts and decrement the counter once per frame; it returns to ALIVE on the edge where the counter reaches 0.
REQ-014 DEAD SHALL be terminal until reset: position frozen, no bomb_drop, no damage.
REQ-015 bomb_drop SHALL pulse one frame on the rising edge of keycode==KEY_BOMB (previous frame not KEY_BOMB), only when the cooldown is 0 and the state is not DEAD.
REQ-016 A drop SHALL load cooldown = BOMB_COOLDOWN; cooldown decrements to 0 every frame.
REQ-017 drop_x SHALL be ((userX+W/2-ORIGIN) & ~(TILE-1))+ORIGIN, with drop_y analogous using H, latched with the pulse and held otherwise.
REQ-018 Overlap and bomb press in the same frame: damage wins; no bomb_drop, and cooldown unchanged.
REQ-019 The damage edge SHALL suppress movement in that frame.

Reset
REQ-020 While Reset is low, asynchronously:
- userX/userY = SPAWN_X/SPAWN_Y; heart = LIVES; state ALIVE
- counters 0; key history cleared
- bomb_drop, damage, collide, dead = 0
- drop_x/drop_y = 0
REQ-021 Reset asserted mid-INVULN or mid-cooldown SHALL abort both with no residual pulse.

Verification
REQ-022 Reset, hold KEY_RIGHT 20 frames -> userX 544..556, stays 556 (X_MAX bound); userY 416.
REQ-023 Reset, KEY_LEFT 8 frames (userX=536), then KEY_UP 5 frames -> userY stays 416 (pillar corner at 536,415).
REQ-024 Reset, blast (512,416,64,32) valid -> next edge damage=1 one frame, heart 3->2, collide=1 for 120 frames, a repeat blast at frame 50 is ignored; blasts after expiry -> heart 1, then 0 and dead=1.
REQ-025 Reset, hold KEY_BOMB 10 frames -> exactly one bomb_drop, drop=(544,416); re-press at frame 30 -> none; re-press at frame 61 -> pulse.
REQ-026 Blast overlap and KEY_BOMB press in the same frame -> damage=1, bomb_drop=0; Reset pulled low mid-INVULN -> heart=3, collide=0 immediately.
